// File: rtl/pc_unit.sv
// Fetch program counter with stall, absolute/relative jumps, trap redirect
// and a circular return-address stack for call/return.
module pc_unit #(
  parameter int XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int INC       = 4,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         jmp,
  input  logic                         rel,
  input  logic [XLEN-1:0]              nxt,
  input  logic                         call,
  input  logic                         ret,
  input  logic                         trap,
  input  logic [XLEN-1:0]              tvec,
  output logic [XLEN-1:0]              cur,
  output logic [$clog2(RAS_DEPTH):0]   ras_cnt,
  output logic                         fault
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);
  localparam logic [CW-1:0]   FULL_CNT   = CW'(RAS_DEPTH);

  logic [XLEN-1:0] cur_reg, cur_next;
  logic [CW-1:0]   ras_cnt_reg, ras_cnt_next;
  logic [PW-1:0]   wp_reg, wp_next;
  logic            fault_reg, fault_next;
  logic            push;

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] ras_top;
  logic            misaligned;

  assign seq_pc     = cur_reg + XLEN'(INC);
  assign target     = rel ? (cur_reg + nxt) : nxt;
  assign misaligned = |(target & ALIGN_MASK);
  // Read is combinational so a push is poppable in the very next cycle.
  assign ras_top    = ras_mem[wp_reg - PW'(1)];

  always_comb begin
    cur_next     = cur_reg;
    ras_cnt_next = ras_cnt_reg;
    wp_next      = wp_reg;
    fault_next   = 1'b0;
    push         = 1'b0;
    if (trap) begin
      cur_next = tvec;
    end else if (stall) begin
      cur_next = cur_reg;
    end else if (ret) begin
      if (ras_cnt_reg == '0) begin
        fault_next = 1'b1;
      end else begin
        cur_next     = ras_top;
        ras_cnt_next = ras_cnt_reg - CW'(1);
        wp_next      = wp_reg - PW'(1);
      end
    end else if (jmp) begin
      if (misaligned) begin
        fault_next = 1'b1;
      end else begin
        cur_next = target;
        if (call) begin
          push    = 1'b1;
          wp_next = wp_reg + PW'(1);
          // A full stack overwrites its oldest entry; the count saturates.
          if (ras_cnt_reg != FULL_CNT) ras_cnt_next = ras_cnt_reg + CW'(1);
        end
      end
    end else begin
      cur_next = seq_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_reg     <= RESET_VEC;
      ras_cnt_reg <= '0;
      wp_reg      <= '0;
      fault_reg   <= 1'b0;
    end else begin
      cur_reg     <= cur_next;
      ras_cnt_reg <= ras_cnt_next;
      wp_reg      <= wp_next;
      fault_reg   <= fault_next;
    end
  end

  // Stack contents carry no reset; validity is tracked by ras_cnt alone.
  generate
    for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
      always_ff @(posedge clk) begin
        if (push && (wp_reg == PW'(gi))) ras_mem[gi] <= seq_pc;
      end
    end
  endgenerate

  assign cur     = cur_reg;
  assign ras_cnt = ras_cnt_reg;
  assign fault   = fault_reg;

endmodule
